control_sequencer: RTL

// Multi-cycle fetch/decode/execute sequencer; directly downstream of the instruction memory, PC register and branch logic.
// - Drives PC enable; latches the registered 16-bit memory word into an instruction register; decodes fields.
// - Handshakes with the ALU (start/done) and holds last_alu_result for branch evaluation.

---
 rtl/control_sequencer.sv | 89 ++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/memwait/decode/exec/wb sequencer with ALU handshake, done timeout and sticky halt/error.
// Optional CTRL_RETIRE_CNT_EN adds a wrapping retire counter output.
module control_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int INSTR_W      = 16,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               alu_done,
  input  logic [15:0]        alu_result,
  output logic               en_pc,
  output logic               alu_start,
  output logic [3:0]         alu_op,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [7:0]         imm,
  output logic               reg_we,
  output logic [15:0]        last_alu_result,
  output logic               halted,
  output logic               error
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0]        retire_cnt
`endif
);
  typedef enum logic [2:0] {FETCH, MEMWAIT, DECODE, EXEC, WB, HALT} state_t;
  state_t st, nxt;
  logic [INSTR_W-1:0] ir;
  logic [7:0] timer;
  logic tmo;
  logic unused_ir;
  if (ADDR_W < 1 || INSTR_W < 16 || DONE_TIMEOUT < 1 || DONE_TIMEOUT > 255) begin : g_bad_cfg
    $error("control_sequencer: unsupported parameter values");
  end
  assign alu_op    = ir[15:12];
  assign rd        = ir[11:8];
  assign rs        = ir[7:4];
  assign imm       = ir[11:4];
  assign halted    = st == HALT;
  assign unused_ir = ^ir[3:2];
  assign tmo       = timer == 8'(DONE_TIMEOUT - 1);
  always_comb begin
    nxt       = st;
    en_pc     = 1'b0;
    alu_start = 1'b0;
    reg_we    = 1'b0;
    case (st)
      FETCH:   nxt = MEMWAIT;
      MEMWAIT: nxt = DECODE;
      DECODE: begin
        alu_start = ir[1:0] == 2'b00;
        en_pc     = ir[1:0] == 2'b10;
        nxt       = ir[1:0] == 2'b00 ? EXEC : ir[1:0] == 2'b01 ? WB : ir[1:0] == 2'b10 ? FETCH : HALT;
      end
      EXEC:    nxt = alu_done ? WB : tmo ? HALT : EXEC;
      WB: begin
        reg_we = 1'b1;
        en_pc  = 1'b1;
        nxt    = FETCH;
      end
      default: nxt = HALT;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st              <= FETCH;
      ir              <= '0;
      last_alu_result <= '0;
      timer           <= '0;
      error           <= 1'b0;
    end else begin
      st <= nxt;
      if (st == MEMWAIT) ir <= instr_in;
      if (st == EXEC && alu_done) last_alu_result <= alu_result;
      if (st == DECODE) timer <= '0;
      else if (st == EXEC && !alu_done) timer <= timer + 8'd1;
      if (st == EXEC && !alu_done && tmo) error <= 1'b1;
    end
  end
`ifdef CTRL_RETIRE_CNT_EN
  // en_pc fires only on WB exit and on a taken BRANCH decode, exactly the retire events
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retire_cnt <= '0;
    else if (en_pc) retire_cnt <= retire_cnt + 16'd1;
  end
`endif
endmodule
